// File: rtl/barrel_pkg.sv
// Shared types and the neighbour invariant for the barrel shifter / register-file pair.
package barrel_pkg;
  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = $clog2(N_DEFAULT);

  typedef logic [W_DEFAULT-1:0] entry_t;
  typedef enum logic [1:0] {FILL, CHECK, OFFER} loader_state_t;

  // Any entry matching in both images must be followed by matching successors.
  function automatic logic barrel_invariant(input entry_t [N_DEFAULT-1:0] b,
                                            input entry_t [N_DEFAULT-1:0] r);
    logic ok;
    int   inx, jnx;
    ok = 1'b1;
    for (int i = 0; i < N_DEFAULT; i++) begin
      for (int j = 0; j < N_DEFAULT; j++) begin
        inx = (i + 1) % N_DEFAULT;
        jnx = (j + 1) % N_DEFAULT;
        if (b[j] == r[i] && b[jnx[W_DEFAULT-1:0]] != r[inx[W_DEFAULT-1:0]]) ok = 1'b0;
      end
    end
    return ok;
  endfunction
endpackage

// File: rtl/barrel_invariant_check.sv
// Combinational invariant check over flattened shifter / register-file images.
module barrel_invariant_check #(
  parameter int N = barrel_pkg::N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic [N*W-1:0] b_flat,
  input  logic [N*W-1:0] r_flat,
  output logic           ok
);
  import barrel_pkg::*;

  assign ok = barrel_invariant(b_flat, r_flat);
endmodule

// File: rtl/barrel_state_loader.sv
// Collects 2*N words into b/r images, zeroes images that break the invariant, offers them downstream.
module barrel_state_loader #(
  parameter int N = barrel_pkg::N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           load_valid,
  input  logic           load_ready,
  output logic [N*W-1:0] b_flat,
  output logic [N*W-1:0] r_flat,
  output logic           remapped
);
  import barrel_pkg::*;

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST = CW'(2*N-1);
  localparam logic [CW-1:0] NC   = CW'(N);

  loader_state_t         state_q, state_d;
  logic [CW-1:0]         count_q, idx;
  logic [N-1:0][W-1:0]   b_q, r_q;
  logic                  ok, accept;

  barrel_invariant_check #(.N(N), .W(W)) u_chk (
    .b_flat (b_q),
    .r_flat (r_q),
    .ok     (ok)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    load_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && count_q == LAST) state_d = CHECK;
      end
      CHECK: state_d = OFFER;
      OFFER: begin
        load_valid = 1'b1;
        if (load_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign idx    = (count_q < NC) ? count_q : count_q - NC;

  // Buffers are the output image; they are only rewritten word-by-word during the next fill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      b_q      <= '0;
      r_q      <= '0;
      remapped <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
        if (count_q < NC) b_q[idx[W-1:0]] <= in_data;
        else              r_q[idx[W-1:0]] <= in_data;
      end
      if (state_q == CHECK) begin
        remapped <= !ok;
        if (!ok) begin
          b_q <= '0;
          r_q <= '0;
        end
      end
    end
  end

  assign b_flat = b_q;
  assign r_flat = r_q;
endmodule

// File: tb/tb_barrel_state_loader.sv
// Scoreboarded bench for barrel_state_loader with directed and randomized images.
module tb_barrel_state_loader;
  localparam int N = 4;
  localparam int W = 2;

  logic           clock = 1'b0;
  logic           reset_n, in_valid, in_ready, load_valid, load_ready, remapped;
  logic [W-1:0]   in_data;
  logic [N*W-1:0] b_flat, r_flat;

  barrel_state_loader #(.N(N), .W(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .b_flat     (b_flat),
    .r_flat     (r_flat),
    .remapped   (remapped)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N*W-1:0] b;
    logic [N*W-1:0] r;
    logic           rm;
  } img_t;

  img_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: words 0..N-1 form b, N..2N-1 form r; any mismatched successor pair voids the image.
  function automatic img_t model(input int w[2*N]);
    img_t e;
    bit   good;
    good = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (w[j] == w[N+i] && w[(j+1)%N] != w[N+(i+1)%N]) good = 1'b0;
    e.b  = '0;
    e.r  = '0;
    e.rm = !good;
    if (good)
      for (int i = 0; i < N; i++) begin
        e.b[W*i +: W] = w[i][W-1:0];
        e.r[W*i +: W] = w[N+i][W-1:0];
      end
    return e;
  endfunction

  task automatic monitor();
    img_t cur;
    bit   seen;
    seen = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) seen = 1'b0;
      else if (load_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) chk("unexpected_offer", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("offer_b", b_flat, cur.b);
            chk("offer_r", r_flat, cur.r);
            chk("offer_remapped", remapped, cur.rm);
          end
          seen = 1'b1;
        end else begin
          chk("hold_b", b_flat, cur.b);
          chk("hold_r", r_flat, cur.r);
          chk("hold_remapped", remapped, cur.rm);
        end
      end else seen = 1'b0;
    end
  endtask

  task automatic run_image(input int w[2*N], input bit gap, input int bp, input bit bp_valid);
    img_t e;
    e = model(w);
    for (int k = 0; k < 2*N; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
      if (k == 0) chk("fill_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = w[k][W-1:0];
      if (k == 2*N-1) exp_q.push_back(e);
      @(posedge clock); #1;
    end
    in_valid = bp_valid;
    in_data  = 2'd3;
    chk("check_load_valid", load_valid, 0);
    chk("check_in_ready", in_ready, 0);
    @(posedge clock); #1;
    chk("offer_latency", load_valid, 1);
    chk("offer_in_ready", in_ready, 0);
    repeat (bp) begin @(posedge clock); #1; end
    if (bp > 0) chk("bp_load_valid", load_valid, 1);
    load_ready = 1'b1;
    @(posedge clock); #1;
    load_ready = 1'b0;
    in_valid   = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_load_valid", load_valid, 0);
    chk("post_b", b_flat, e.b);
    chk("post_r", r_flat, e.r);
    chk("post_remapped", remapped, e.rm);
  endtask

  initial begin
    int w[2*N];
    int rot;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    load_ready = 1'b0;
    fork
      monitor();
      begin
        repeat (50000) @(posedge clock);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
      end
    join_none
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_load_valid", load_valid, 0);
    chk("rst_b", b_flat, 0);
    chk("rst_r", r_flat, 0);
    chk("rst_remapped", remapped, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    w = '{0, 1, 2, 3, 1, 2, 3, 0};
    run_image(w, 0, 0, 0);
    chk("rot_b_const", b_flat, 8'hE4);
    chk("rot_r_const", r_flat, 8'h39);
    chk("rot_remapped_const", remapped, 0);

    w = '{0, 1, 2, 3, 0, 2, 1, 3};
    run_image(w, 0, 2, 0);
    chk("bad_b_const", b_flat, 0);
    chk("bad_r_const", r_flat, 0);
    chk("bad_remapped_const", remapped, 1);

    w = '{0, 1, 2, 3, 1, 2, 3, 0};
    run_image(w, 0, 5, 1);
    chk("bp_b_const", b_flat, 8'hE4);

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_b", b_flat, 0);
    chk("midrst_r", r_flat, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_load_valid", load_valid, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    w = '{0, 1, 2, 3, 1, 2, 3, 0};
    run_image(w, 0, 0, 0);
    chk("midrst_reload_b", b_flat, 8'hE4);
    chk("midrst_reload_r", r_flat, 8'h39);

    w = '{2, 2, 2, 2, 2, 2, 2, 2};
    run_image(w, 1, 1, 0);
    chk("gap_b_const", b_flat, 8'hAA);
    chk("gap_r_const", r_flat, 8'hAA);
    chk("gap_remapped_const", remapped, 0);

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 3));
      rot = int'($urandom_range(0, N-1));
      for (int k = 0; k < N; k++)
        w[N+k] = $urandom_range(0, 1) ? w[(k+rot)%N] : int'($urandom_range(0, 3));
      run_image(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
